mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_rr_picker.sv | 26 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Requester identifiers
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    DEBUG = 2'd2
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Two-way round-robin pick between fetch (0) and data (1) with pointer update.
module rr_picker (
  input  logic req_f,
  input  logic req_d,
  input  logic ptr,
  output logic valid_c,
  output logic pick_c,
  output logic ptr_next_c
);

  // Preferred side wins a tie; the pointer moves past whoever was picked
  always_comb begin
    valid_c    = req_f | req_d;
    pick_c     = ptr;
    ptr_next_c = ptr;
    if (req_f && !req_d) begin
      pick_c = 1'b0;
    end else if (req_d && !req_f) begin
      pick_c = 1'b1;
    end
    if (valid_c) begin
      ptr_next_c = ~pick_c;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and three-phase sequencer for the single 8-bit memory port.
// Optional debug requester enabled by defining MEM_ARB_DEBUG_PORT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic              f_write,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic              g_req,
  input  logic              g_write,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic              g_done,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_mem,
  output logic              mem_clock,
  output logic              mem_write,
  input  logic [DATA_W-1:0] from_mem
);

  state_t  state;
  req_id_t cur_id;
  logic    ptr;

  logic              pick_valid_c;
  logic              pick_c;
  logic              pick_ptr_c;
  logic              win_valid_c;
  req_id_t           win_id_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic              win_write_c;
  logic              ptr_nx_c;

  rr_picker u_rr_picker (
    .req_f      (f_req),
    .req_d      (d_req),
    .ptr        (ptr),
    .valid_c    (pick_valid_c),
    .pick_c     (pick_c),
    .ptr_next_c (pick_ptr_c)
  );

  // Winner selection: debug overrides the round-robin pick and leaves the pointer alone
  always_comb begin
    win_valid_c = pick_valid_c;
    win_id_c    = pick_c ? DATA : FETCH;
    win_addr_c  = pick_c ? d_addr : f_addr;
    win_wdata_c = pick_c ? d_wdata : f_wdata;
    win_write_c = pick_c ? d_write : f_write;
    ptr_nx_c    = pick_ptr_c;
`ifdef MEM_ARB_DEBUG_PORT_EN
    if (g_req) begin
      win_valid_c = 1'b1;
      win_id_c    = DEBUG;
      win_addr_c  = g_addr;
      win_wdata_c = g_wdata;
      win_write_c = g_write;
      ptr_nx_c    = ptr;
    end
`endif
  end

  // Sequencer: arbitrate in IDLE/RESP, then SETUP, STROBE, RESP with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_id    <= FETCH;
      ptr       <= 1'b0;
      address   <= '0;
      to_mem    <= '0;
      mem_clock <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= '0;
      f_gnt     <= 1'b0;
      f_done    <= 1'b0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
      g_gnt     <= 1'b0;
      g_done    <= 1'b0;
`endif
    end else begin
      f_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_gnt  <= 1'b0;
      d_done <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
      g_gnt  <= 1'b0;
      g_done <= 1'b0;
`endif
      case (state)
        IDLE, RESP: begin
          if (win_valid_c) begin
            state     <= SETUP;
            cur_id    <= win_id_c;
            ptr       <= ptr_nx_c;
            address   <= win_addr_c;
            to_mem    <= win_wdata_c;
            mem_write <= win_write_c;
            f_gnt     <= (win_id_c == FETCH);
            d_gnt     <= (win_id_c == DATA);
`ifdef MEM_ARB_DEBUG_PORT_EN
            g_gnt     <= (win_id_c == DEBUG);
`endif
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          mem_clock <= 1'b1;
          state     <= STROBE;
        end
        STROBE: begin
          mem_clock <= 1'b0;
          mem_write <= 1'b0;
          if (!mem_write) begin
            rdata <= from_mem;
          end
          f_done <= (cur_id == FETCH);
          d_done <= (cur_id == DATA);
`ifdef MEM_ARB_DEBUG_PORT_EN
          g_done <= (cur_id == DEBUG);
`endif
          state  <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
